btb_branch_predictor: RTL and testbench

//  Parametrised next-PC predictor for the pipelined RV32 core (control-hazard generation).
//  - IF stage: presents the current PC and gets a predicted next PC in the same cycle.
//  - EX stage: reports each resolved branch/jump; the block trains a direct-mapped BTB and a 2-bit counter table.
//  - Indexing mode: bimodal (PC-indexed) or gshare (PC XOR global history), selected at elaboration.

---
 rtl/bp_pkg.sv | 38 +++
 rtl/bp_counter_table.sv | 35 +++
 rtl/btb_branch_predictor.sv | 118 +++++++++++
 tb/tb_btb_branch_predictor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the next-PC predictor.
// Counter encodings, saturating update and table geometry.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  localparam int DEF_ENTRIES = 32;
  localparam int DEF_XLEN    = 32;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  localparam int IDX_W = idx_w(DEF_ENTRIES);
  localparam int TAG_W = tag_w(DEF_XLEN, DEF_ENTRIES);

  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    cnt_t nxt;
    nxt = cnt;
    unique case (cnt)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2-bit saturating counter array, reset to weakly-not-taken.
// Two combinational read ports, one synchronous write port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] a_idx,
  output cnt_t          a_cnt,
  input  logic [IW-1:0] b_idx,
  output cnt_t          b_cnt,
  input  logic          we,
  input  logic [IW-1:0] w_idx,
  input  cnt_t          w_cnt
);

  cnt_t tbl [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= WNT;
      end
    end else if (we) begin
      tbl[w_idx] <= w_cnt;
    end
  end

  assign a_cnt = tbl[a_idx];
  assign b_cnt = tbl[b_idx];

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB plus bimodal/gshare counters for IF next-PC.
// Lookup is combinational; EX updates land on the next edge.
module btb_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int GSHARE  = 0,
  parameter int HIST_W  = 5,
  parameter int XLEN    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   pred_next_pc,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  output logic              upd_mispredict,
  output logic [HIST_W-1:0] ghr_out
);

  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(XLEN, ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [HIST_W-1:0]  ghr;

  logic [IW-1:0]   hist;
  logic [IW-1:0]   if_idx;
  logic [IW-1:0]   up_idx;
  logic [IW-1:0]   if_cidx;
  logic [IW-1:0]   up_cidx;
  logic [TW-1:0]   if_tag;
  logic [TW-1:0]   up_tag;
  cnt_t            if_cnt;
  cnt_t            up_cnt;
  cnt_t            w_cnt;
  logic            we;
  logic            taken_eff;
  logic            if_hit;
  logic            up_hit;
  logic            up_pred_t;
  logic [XLEN-1:0] up_pred_pc;
  logic [XLEN-1:0] actual_pc;
  logic            unused_lsb;

  assign hist    = (GSHARE != 0) ? IW'(ghr) : '0;
  assign if_idx  = if_pc[IW+1:2];
  assign up_idx  = upd_pc[IW+1:2];
  assign if_tag  = if_pc[XLEN-1:IW+2];
  assign up_tag  = upd_pc[XLEN-1:IW+2];
  assign if_cidx = if_idx ^ hist;
  assign up_cidx = up_idx ^ hist;

  assign unused_lsb = ^{if_pc[1:0], upd_pc[1:0]};

  bp_counter_table #(
    .ENTRIES (ENTRIES),
    .IW      (IW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .a_idx (if_cidx),
    .a_cnt (if_cnt),
    .b_idx (up_cidx),
    .b_cnt (up_cnt),
    .we    (we),
    .w_idx (up_cidx),
    .w_cnt (w_cnt)
  );

  // Tables are stale during the reset cycle, so force not-taken.
  assign if_hit       = valid[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken   = !reset && if_hit && if_cnt[1];
  assign pred_next_pc = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);

  assign up_hit     = valid[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_pred_t  = !reset && up_hit && up_cnt[1];
  assign up_pred_pc = up_pred_t ? tgt_q[up_idx] : upd_pc + XLEN'(4);
  assign taken_eff  = upd_is_jump | upd_taken;
  assign actual_pc  = taken_eff ? upd_target : upd_pc + XLEN'(4);

  assign upd_mispredict = upd_valid && (up_pred_pc != actual_pc);

  assign we    = upd_valid && !reset;
  assign w_cnt = upd_is_jump ? ST : sat_update(up_cnt, upd_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (we && taken_eff) begin
      valid[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && taken_eff) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (we) begin
      ghr <= (ghr << 1) | HIST_W'(taken_eff);
    end
  end

  assign ghr_out = ghr;

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Bench for btb_branch_predictor: bimodal and gshare instances
// against an array-based reference model, directed then random.
module tb_btb_branch_predictor;

  localparam int E = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;

  logic [31:0] pn0, pn1;
  logic        pt0, pt1;
  logic        mp0, mp1;
  logic [4:0]  gh0, gh1;

  int vectors    = 0;
  int miscompares = 0;

  int          m_cnt [2][E];
  bit          m_val [2][E];
  logic [31:0] m_tag [2][E];
  logic [31:0] m_tgt [2][E];
  int          mghr;

  always #5 clk = ~clk;

  btb_branch_predictor #(
    .ENTRIES (32),
    .GSHARE  (0),
    .HIST_W  (5),
    .XLEN    (32)
  ) u_bim (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_next_pc   (pn0),
    .pred_taken     (pt0),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (mp0),
    .ghr_out        (gh0)
  );

  btb_branch_predictor #(
    .ENTRIES (32),
    .GSHARE  (1),
    .HIST_W  (5),
    .XLEN    (32)
  ) u_gsh (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_next_pc   (pn1),
    .pred_taken     (pt1),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (mp1),
    .ghr_out        (gh1)
  );

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % E);
  endfunction

  function automatic int cidx(input int k, input logic [31:0] pc);
    return (k == 1) ? (bidx(pc) ^ mghr) : bidx(pc);
  endfunction

  function automatic bit mtaken(input int k, input logic [31:0] pc);
    int i;
    if (reset) return 1'b0;
    i = bidx(pc);
    return m_val[k][i] && (m_tag[k][i] == (pc >> 7))
           && (m_cnt[k][cidx(k, pc)] >= 2);
  endfunction

  function automatic logic [31:0] mnext(input int k, input logic [31:0] pc);
    if (mtaken(k, pc)) return m_tgt[k][bidx(pc)];
    return pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] act;
    bit te;
    te  = upd_is_jump | upd_taken;
    act = te ? upd_target : upd_pc + 32'd4;
    chk("bim_taken", {31'd0, pt0}, {31'd0, mtaken(0, if_pc)});
    chk("bim_next", pn0, mnext(0, if_pc));
    chk("bim_mispred", {31'd0, mp0},
        {31'd0, upd_valid && (mnext(0, upd_pc) != act)});
    chk("gsh_taken", {31'd0, pt1}, {31'd0, mtaken(1, if_pc)});
    chk("gsh_next", pn1, mnext(1, if_pc));
    chk("gsh_mispred", {31'd0, mp1},
        {31'd0, upd_valid && (mnext(1, upd_pc) != act)});
    chk("gsh_ghr", {27'd0, gh1}, 32'(mghr));
  endtask

  task automatic model_update();
    bit te;
    int c, i;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < E; j++) begin
          m_cnt[k][j] = 1;
          m_val[k][j] = 1'b0;
        end
      end
      mghr = 0;
    end else if (upd_valid) begin
      te = upd_is_jump | upd_taken;
      i  = bidx(upd_pc);
      for (int k = 0; k < 2; k++) begin
        c = cidx(k, upd_pc);
        if (upd_is_jump) m_cnt[k][c] = 3;
        else if (te) m_cnt[k][c] = (m_cnt[k][c] == 3) ? 3 : m_cnt[k][c] + 1;
        else m_cnt[k][c] = (m_cnt[k][c] == 0) ? 0 : m_cnt[k][c] - 1;
        if (te) begin
          m_val[k][i] = 1'b1;
          m_tag[k][i] = upd_pc >> 7;
          m_tgt[k][i] = upd_target;
        end
      end
      mghr = ((mghr << 1) | int'(te)) % 32;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic v,
                       input logic [31:0] upc, input logic j,
                       input logic t, input logic [31:0] tgt,
                       input logic r);
    if_pc       = pc;
    upd_valid   = v;
    upd_pc      = upc;
    upd_is_jump = j;
    upd_taken   = t;
    upd_target  = tgt;
    reset       = r;
  endtask

  task automatic step(input logic [31:0] pc, input logic v,
                      input logic [31:0] upc, input logic j,
                      input logic t, input logic [31:0] tgt,
                      input logic r);
    drive(pc, v, upc, j, t, tgt, r);
    #1;
    check_model();
    tick();
  endtask

  task automatic look(input logic [31:0] pc);
    drive(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_model();
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
    if ($urandom_range(0, 7) == 0) p = p | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) p = p | 32'hFFFF_FE00;
    return p;
  endfunction

  initial begin
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    tick();
    tick();

    look(32'h40);
    chk("t1_taken", {31'd0, pt0}, 32'd0);
    chk("t1_next", pn0, 32'h44);
    tick();

    drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    #1;
    check_model();
    chk("t5_same_cycle_taken", {31'd0, pt0}, 32'd0);
    chk("t5_mispredict", {31'd0, mp0}, 32'd1);
    tick();

    look(32'h40);
    chk("t2_taken", {31'd0, pt0}, 32'd1);
    chk("t2_next", pn0, 32'h100);
    tick();

    step(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    chk("t3_snt_taken", {31'd0, pt0}, 32'd0);
    tick();
    step(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    chk("t3_wnt_taken", {31'd0, pt0}, 32'd0);
    tick();
    step(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    chk("t3_wt_next", pn0, 32'h100);
    tick();

    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    step(32'h0, 1'b1, 32'hC0, 1'b0, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    chk("t4_old_tag_taken", {31'd0, pt0}, 32'd0);
    chk("t4_old_tag_next", pn0, 32'h44);
    tick();
    look(32'hC0);
    chk("t4_new_tag_next", pn0, 32'h200);
    tick();

    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    step(32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h180, 1'b0);
    step(32'h0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h300, 1'b0);
    look(32'h40);
    chk("t6_ghr", {27'd0, gh1}, 32'h0D);
    tick();

    drive(32'h40, 1'b1, 32'h4C, 1'b0, 1'b1, 32'h400, 1'b1);
    #1;
    check_model();
    chk("t6_reset_taken", {31'd0, pt0}, 32'd0);
    chk("t6_reset_next", pn0, 32'h44);
    tick();
    look(32'h4C);
    chk("t6_ghr_cleared", {27'd0, gh1}, 32'd0);
    chk("t6_dropped_next", pn0, 32'h50);
    tick();

    look(32'hFFFF_FFFC);
    chk("wrap_next", pn0, 32'h0);
    tick();

    for (int n = 0; n < 800; n++) begin
      step(rpc(), ($urandom_range(0, 9) < 7), rpc(),
           ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
           $urandom, ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
